servant_uart_monitor: RTL and testbench
=======================================

// Module: servant_uart_monitor
// PURPOSE
// - Clocked UART receiver that decodes the serial TX line (q) of the servant
//   simulation SoC into bytes, so the console output of programs such as
//   hello_uart can be checked.
// - Sits beside the SoC on the same wb_clk domain.
// - Fixed frame format: 8N1, LSB first.
// - Reports each received byte, newline characters, framing errors and a
//   running byte count.
// PARAMETERS
// - CLK_FREQ_HZ  16000000  wb_clk frequency in Hz (62-unit clock period in the servant bench).
// - BAUD_RATE    172800    Line rate in bit/s. Use 57600*3 for width=4 cores; 57600 otherwise.
// - CLKS_PER_BIT derived   (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE. This is 93 at the defaults.
//   - Must be >= 8; elaboration error otherwise.
// PORTS
// - wb_clk      in   1   System clock. All logic is on the rising edge.
// - wb_rst      in   1   Asynchronous, active-high reset.
// - q           in   1   Serial line from the SoC. Idle high. Asynchronous to wb_clk.
// - rx_data     out  8   Last correctly framed byte.
// - rx_valid    out  1   1-cycle pulse; rx_data is new on that cycle.
// - rx_newline  out  1   1-cycle pulse, coincident with rx_valid, when rx_data == 8'h0A.
// - frame_err   out  1   1-cycle pulse when the stop bit is sampled low.
// - byte_count  out  16  Number of rx_valid pulses since reset. Wraps at 16'hFFFF.
// BEHAVIOUR
// - Reset values:
//   - rx_data = 0, byte_count = 0.
//   - All pulse outputs = 0.
//   - Synchroniser flops = 1 (line idle).
//   - FSM = IDLE, bit counter = 0, clock counter = 0.
// - Synchroniser: q passes through 2 flops to give rxs. FSM decisions use rxs only.
// - FSM states and transitions:
//   - IDLE: rxs == 0 -> START, clock counter cleared.
//   - START: count to CLKS_PER_BIT/2 - 1 (mid start bit).
//     - rxs == 0 -> DATA, counters cleared.
//     - rxs == 1 -> IDLE. This is a glitch: no outputs.
//   - DATA: every CLKS_PER_BIT clocks, sample rxs into shift register bit[n], n = 0..7, LSB first.
//     - After bit 7 -> STOP.
//   - STOP: after CLKS_PER_BIT clocks, sample rxs.
//     - rxs == 1: rx_data <= shift register, rx_valid = 1, rx_newline as defined,
//       byte_count + 1, -> IDLE.
//     - rxs == 0: frame_err = 1, rx_data unchanged, -> WAIT_HIGH.
//   - WAIT_HIGH: stay until rxs == 1, then -> IDLE. Prevents a break from
//     re-triggering.
// - Latency: rx_valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks after
//   the falling start edge on q (+/-1 clk).
// - A back-to-back frame is accepted: a start edge in IDLE right after the
//   stop sample is detected. Total slack is at least CLKS_PER_BIT/2.
// - rx_data holds its value between frames. The outputs have no ready/backpressure.
// - wb_rst asserted mid-frame aborts the frame. No pulses are produced for it,
//   and the counters clear immediately.
// - byte_count wraps from 16'hFFFF to 0 without other side effects.
// TESTING
// - Defaults: drive 8'h48 ('H') at 93 clk/bit -> one rx_valid, rx_data = 8'h48,
//   rx_newline = 0, byte_count = 1.
// - Drive "Hi\n" back-to-back with a 1-bit stop:
//   - 3 rx_valid pulses with data 48, 69, 0A.
//   - rx_newline only on the third pulse; byte_count = 3.
// - Drive q low for 20 clks, then high -> no rx_valid, no frame_err, FSM back in IDLE.
// - Drive 8'h55 with stop bit 0, then line high:
//   - frame_err pulses once, rx_valid = 0, rx_data unchanged, byte_count unchanged.
//   - A following 8'hA5 frame decodes correctly.
// - Assert wb_rst during data bit 4 of a frame:
//   - All outputs reset, no pulses.
//   - The next full frame 8'h0A decodes, with rx_newline = 1.
// - Preload 65535 frames (or force byte_count to 16'hFFFF), send 1 byte ->
//   byte_count = 0, rx_valid = 1.

Source files
------------

// File: rtl/servant_uart_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : servant_uart_monitor_if
//  Purpose  : Bundles the serial line and decoded-byte reporting signals that
//             run between the servant SoC side and the UART monitor.
//  Ports    : q          - serial TX line from the SoC, idle high
//             rx_data    - last correctly framed byte
//             rx_valid   - 1-cycle pulse, rx_data is new
//             rx_newline - 1-cycle pulse with rx_valid when rx_data == 8'h0A
//             frame_err  - 1-cycle pulse when the stop bit is sampled low
//             byte_count - number of rx_valid pulses since reset (wraps)
//  Modports : master - drives q and observes the decoded results
//             slave  - the monitor; samples q and drives the results
//  Revision : 1.0 - initial release
// ============================================================================
interface servant_uart_monitor_if;
    logic        q;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_newline;
    logic        frame_err;
    logic [15:0] byte_count;

    modport master (
        output q,
        input  rx_data,
        input  rx_valid,
        input  rx_newline,
        input  frame_err,
        input  byte_count
    );

    modport slave (
        input  q,
        output rx_data,
        output rx_valid,
        output rx_newline,
        output frame_err,
        output byte_count
    );
endinterface
`default_nettype wire

// File: rtl/servant_uart_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : servant_uart_monitor
//  Purpose  : Clocked 8N1 UART receiver (LSB first) that decodes the servant
//             SoC serial TX line into bytes, flags newlines and framing
//             errors, and keeps a running count of received bytes.
//  Ports    : wb_clk - system clock, all logic on the rising edge
//             wb_rst - asynchronous, active-high reset
//             bus    - servant_uart_monitor_if.slave (q in; rx_data,
//                      rx_valid, rx_newline, frame_err, byte_count out)
//  Params   : CLK_FREQ_HZ - clock frequency in Hz
//             BAUD_RATE   - line rate in bit/s
//  Revision : 1.0 - initial release
// ============================================================================
module servant_uart_monitor #(
    parameter int CLK_FREQ_HZ = 16000000,
    parameter int BAUD_RATE   = 172800
) (
    input  logic                         wb_clk,
    input  logic                         wb_rst,
    servant_uart_monitor_if.slave        bus
);

    // Rounded-to-nearest number of clocks per bit time.
    localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    generate
        if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
            $error("servant_uart_monitor: CLKS_PER_BIT must be >= 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    state_t              state;
    logic                sync_meta;
    logic                rxs;
    logic [CNT_W-1:0]    clk_cnt;
    logic [2:0]          bit_cnt;
    logic [7:0]          shift_reg;
    logic [7:0]          data_reg;
    logic                valid_reg;
    logic                newline_reg;
    logic                ferr_reg;
    logic [15:0]         count_reg;

    // Two-flop synchroniser; reset to the idle (high) line level so a reset
    // release never looks like a start edge.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            sync_meta <= 1'b1;
            rxs       <= 1'b1;
        end else begin
            sync_meta <= bus.q;
            rxs       <= sync_meta;
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state       <= ST_IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            newline_reg <= 1'b0;
            ferr_reg    <= 1'b0;
            count_reg   <= '0;
        end else begin
            // Pulse outputs are single-cycle unless re-asserted below.
            valid_reg   <= 1'b0;
            newline_reg <= 1'b0;
            ferr_reg    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state   <= ST_START;
                        clk_cnt <= '0;
                    end
                end

                ST_START: begin
                    // Re-check the line at mid start bit to reject glitches.
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt            <= '0;
                        shift_reg[bit_cnt] <= rxs;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rxs) begin
                            data_reg    <= shift_reg;
                            valid_reg   <= 1'b1;
                            newline_reg <= (shift_reg == 8'h0A);
                            count_reg   <= count_reg + 16'd1;
                            state       <= ST_IDLE;
                        end else begin
                            ferr_reg <= 1'b1;
                            state    <= ST_WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                ST_WAIT_HIGH: begin
                    // A held-low line (break) must not start a new frame.
                    if (rxs) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_data    = data_reg;
    assign bus.rx_valid   = valid_reg;
    assign bus.rx_newline = newline_reg;
    assign bus.frame_err  = ferr_reg;
    assign bus.byte_count = count_reg;

endmodule
`default_nettype wire

// File: tb/tb_servant_uart_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_servant_uart_monitor
//  Purpose  : Self-checking bench for servant_uart_monitor. Frames are driven
//             onto q at the default bit rate; expected bytes are queued when a
//             frame is driven and compared when rx_valid pulses.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_servant_uart_monitor;

    localparam int CLK_FREQ_HZ = 16000000;
    localparam int BAUD_RATE   = 172800;
    localparam int CPB         = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int LATENCY     = 2 + CPB / 2 + 9 * CPB;

    typedef struct {
        logic [7:0]  data;
        logic        nl;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst;

    servant_uart_monitor_if bus ();

    servant_uart_monitor #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD_RATE   (BAUD_RATE)
    ) dut (
        .wb_clk (clk),
        .wb_rst (rst),
        .bus    (bus.slave)
    );

    exp_t        sb[$];
    int          n_checks;
    int          n_fail;
    int          ferr_seen;
    int          cyc;
    int          start_cyc;
    logic [15:0] exp_count;

    initial clk = 1'b0;
    always #31 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d);
        exp_t e;
        exp_count = exp_count + 16'd1;
        e.data = d;
        e.nl   = (d == 8'h0A);
        e.cnt  = exp_count;
        sb.push_back(e);
    endtask

    // Called at a negedge; drives a full frame, returns at a negedge.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        bus.q = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.q = d[i];
            repeat (CPB) @(negedge clk);
        end
        bus.q = stop;
        repeat (CPB) @(negedge clk);
        bus.q = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check_value("drain_timeout", sb.size(), 0);
        repeat (10) @(negedge clk);
    endtask

    // Output monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid) begin
                if (sb.size() == 0) begin
                    check_value("unexpected_valid", 32'(bus.rx_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    int   lat;
                    e   = sb.pop_front();
                    lat = cyc - start_cyc;
                    check_value("rx_data", 32'(bus.rx_data), 32'(e.data));
                    check_value("rx_newline", 32'(bus.rx_newline), 32'(e.nl));
                    check_value("byte_count", 32'(bus.byte_count), 32'(e.cnt));
                    check_value("latency_window", 32'(lat >= LATENCY - 1 && lat <= LATENCY + 1), 32'd1);
                end
            end else if (bus.rx_newline) begin
                check_value("newline_without_valid", 32'(bus.rx_newline), 32'd0);
            end
            if (bus.frame_err) ferr_seen++;
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        ferr_seen = 0;
        cyc       = 0;
        start_cyc = 0;
        exp_count = 16'd0;
        bus.q     = 1'b1;
        rst       = 1'b1;

        // Reset state
        repeat (5) @(negedge clk);
        check_value("reset_rx_data", 32'(bus.rx_data), 32'h0);
        check_value("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
        check_value("reset_rx_newline", 32'(bus.rx_newline), 32'h0);
        check_value("reset_frame_err", 32'(bus.frame_err), 32'h0);
        check_value("reset_byte_count", 32'(bus.byte_count), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte 'H'
        push_exp(8'h48);
        send_byte(8'h48, 1'b1);
        drain();

        // "Hi\n" back-to-back with one stop bit
        push_exp(8'h48);
        send_byte(8'h48, 1'b1);
        push_exp(8'h69);
        send_byte(8'h69, 1'b1);
        push_exp(8'h0A);
        send_byte(8'h0A, 1'b1);
        drain();

        // Start-bit glitch: 20 clocks low, then idle
        bus.q = 1'b0;
        repeat (20) @(negedge clk);
        bus.q = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_value("glitch_no_frame_err", ferr_seen, 0);
        check_value("glitch_count_kept", 32'(bus.byte_count), 32'(exp_count));

        // Framing error on 0x55, then a good 0xA5
        send_byte(8'h55, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check_value("frame_err_once", ferr_seen, 1);
        check_value("ferr_rx_data_kept", 32'(bus.rx_data), 32'h0A);
        check_value("ferr_count_kept", 32'(bus.byte_count), 32'(exp_count));
        push_exp(8'hA5);
        send_byte(8'hA5, 1'b1);
        drain();

        // Reset during data bit 4 of a frame
        start_cyc = cyc;
        bus.q = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.q = i[0];
            repeat (CPB) @(negedge clk);
        end
        bus.q = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_value("midframe_rst_rx_data", 32'(bus.rx_data), 32'h0);
        check_value("midframe_rst_count", 32'(bus.byte_count), 32'h0);
        check_value("midframe_rst_valid", 32'(bus.rx_valid), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_count = 16'd0;
        repeat (2 * CPB) @(negedge clk);
        check_value("post_rst_no_frame_err", ferr_seen, 1);
        push_exp(8'h0A);
        send_byte(8'h0A, 1'b1);
        drain();

        // byte_count wrap from 16'hFFFF to 0
        force dut.count_reg = 16'hFFFF;
        @(negedge clk);
        release dut.count_reg;
        exp_count = 16'hFFFF;
        @(negedge clk);
        push_exp(8'h21);
        send_byte(8'h21, 1'b1);
        drain();
        check_value("wrap_count_zero", 32'(bus.byte_count), 32'h0);

        check_value("total_frame_err", ferr_seen, 1);
        check_value("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
